rr_arb_reg: RTL and testbench

- Round-robin arbiter that shares one registered output stage between REQ_NUM valid/ready requesters.
- Selects one valid requester per cycle and loads its payload plus index into an output register.
- Presents the result downstream with valid/ready flow control.
- Sits between multiple producers (e.g. bus masters, DMA channels) and a single consumer; all state uses the common dffr/dfflr register primitives.

---
 rtl/rr_arb_pkg.sv | 27 ++
 rtl/dfflr.sv | 20 ++
 rtl/dffr.sv | 19 +
 rtl/rr_arb_pick.sv | 32 +++
 rtl/rr_arb_reg.sv | 104 ++++++++++
 tb/tb_rr_arb_reg.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: rotated-priority scan helper.
package rr_arb_pkg;

    localparam int unsigned RR_MAX_REQ = 32;

    // Index of first set bit scanning ptr, ptr+1, ... modulo n; -1 when none set.
    function automatic int rr_scan(input logic [RR_MAX_REQ-1:0] req,
                                   input int n,
                                   input int ptr);
        int result;
        int idx;
        result = -1;
        for (int k = 0; k < int'(RR_MAX_REQ); k++) begin
            if (k < n && result < 0) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dfflr.sv
// Load-enabled register with asynchronous active-low reset to zero.
module dfflr #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dffr.sv
// Plain register with asynchronous active-low reset to zero.
module dffr #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM   = 4,
    parameter int unsigned IDX_WIDTH = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [REQ_NUM-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 any_gnt
);

    logic [RR_MAX_REQ-1:0] req_ext;
    int                    pick;

    always_comb begin
        req_ext                = '0;
        req_ext[REQ_NUM-1:0]   = req;
        pick                   = rr_scan(req_ext, int'(REQ_NUM), int'(ptr));
        gnt                    = '0;
        gnt_idx                = '0;
        any_gnt                = 1'b0;
        if (pick >= 0) begin
            any_gnt      = 1'b1;
            gnt_idx      = IDX_WIDTH'(pick);
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_reg.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
// Optional owner lock enabled with RR_ARB_LOCK_EN.
module rr_arb_reg
    import rr_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [$clog2(REQ_NUM)-1:0]    out_idx_o
`ifdef RR_ARB_LOCK_EN
    ,
    input  logic [REQ_NUM-1:0]            lock_i
`endif
);

    localparam int unsigned IDX_WIDTH = $clog2(REQ_NUM);

    logic                  load_en;
    logic                  xfer;
    logic [REQ_NUM-1:0]    eligible;
    logic [REQ_NUM-1:0]    gnt;
    logic [IDX_WIDTH-1:0]  gnt_idx;
    logic                  any_gnt;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  ptr_nxt;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  valid_nxt;

`ifdef RR_ARB_LOCK_EN
    logic                  locked;
    logic [IDX_WIDTH-1:0]  owner;
    logic [REQ_NUM-1:0]    owner_mask;

    // While locked only the owner may win arbitration.
    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
        eligible          = locked ? (req_valid_i & owner_mask) : req_valid_i;
    end

    dfflr #(.W(1 + IDX_WIDTH)) u_lock_q (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (xfer),
        .d     ({lock_i[gnt_idx], gnt_idx}),
        .q     ({locked, owner})
    );
`else
    assign eligible = req_valid_i;
`endif

    rr_arb_pick #(
        .REQ_NUM   (REQ_NUM),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req     (eligible),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign load_en     = ~out_valid_o | out_ready_i;
    assign req_ready_o = gnt & {REQ_NUM{load_en}};
    assign xfer        = any_gnt & load_en;

    always_comb begin
        sel_data  = req_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        ptr_nxt   = (gnt_idx == IDX_WIDTH'(REQ_NUM - 1)) ? '0 : gnt_idx + IDX_WIDTH'(1);
        valid_nxt = load_en ? any_gnt : out_valid_o;
    end

    dfflr #(.W(DATA_WIDTH + IDX_WIDTH)) u_out_q (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (xfer),
        .d     ({sel_data, gnt_idx}),
        .q     ({out_data_o, out_idx_o})
    );

    dffr #(.W(1)) u_valid_q (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (valid_nxt),
        .q     (out_valid_o)
    );

    dfflr #(.W(IDX_WIDTH)) u_ptr_q (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (xfer),
        .d     (ptr_nxt),
        .q     (ptr)
    );

endmodule

// File: tb/tb_rr_arb_reg.sv
// Directed bench for rr_arb_reg; lock scenario runs only with RR_ARB_LOCK_EN.
module tb_rr_arb_reg;

    localparam int unsigned REQ_NUM    = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned IDX_WIDTH  = 2;

    logic                          clk;
    logic                          rst_n;
    logic [REQ_NUM-1:0]            req_valid;
    logic [REQ_NUM-1:0]            req_ready;
    logic [REQ_NUM*DATA_WIDTH-1:0] req_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [IDX_WIDTH-1:0]          out_idx;
`ifdef RR_ARB_LOCK_EN
    logic [REQ_NUM-1:0]            lock;
`endif

    int checks;
    int errors;

    rr_arb_reg #(
        .REQ_NUM    (REQ_NUM),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx)
`ifdef RR_ARB_LOCK_EN
        ,
        .lock_i      (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] pat(input int i);
        return 32'hA5C3_0000 | 32'(i * 17 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 2'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b idx=%0d data=%h, required 0 0 0", out_valid, out_idx, out_data);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ready: got %b, required 0000", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 2'd0) begin
            errors++;
            $display("FAIL idle_out: valid=%b idx=%0d, required 0 0", out_valid, out_idx);
        end
    endtask

    task automatic test_all_req();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_idx[k])) begin
                errors++;
                $display("FAIL all_req_ready[%0d]: got %b, required one-hot %0d", k, req_ready, exp_idx[k]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx[k]) || out_data !== pat(exp_idx[k])) begin
                errors++;
                $display("FAIL all_req_beat[%0d]: valid=%b idx=%0d data=%h, required 1 %0d %h",
                         k, out_valid, out_idx, out_data, exp_idx[k], pat(exp_idx[k]));
            end
        end
    endtask

    task automatic test_sparse_wrap();
        int exp_idx [4] = '{1, 3, 1, 3};
        req_valid = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx[k]) || out_data !== pat(exp_idx[k])) begin
                errors++;
                $display("FAIL sparse_beat[%0d]: valid=%b idx=%0d data=%h, required 1 %0d %h",
                         k, out_valid, out_idx, out_data, exp_idx[k], pat(exp_idx[k]));
            end
        end
        req_valid = 4'b0000;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 2'd3 || out_data !== pat(3)) begin
            errors++;
            $display("FAIL sparse_idle: valid=%b idx=%0d data=%h, required 0 3 %h", out_valid, out_idx, out_data, pat(3));
        end
    endtask

    task automatic test_stall();
        // ptr is 0 here; a lone request from 2 moves ptr to 3.
        req_valid = 4'b0100;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b, required 0000", k, req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'd2 || out_data !== pat(2)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b idx=%0d data=%h, required 1 2 %h", k, out_valid, out_idx, out_data, pat(2));
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL release_ready: got %b, required 1000", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd3 || out_data !== pat(3)) begin
            errors++;
            $display("FAIL release_beat: valid=%b idx=%0d data=%h, required 1 3 %h", out_valid, out_idx, out_data, pat(3));
        end
    endtask

    task automatic test_mid_reset();
        // ptr is 0 after the idx-3 beat.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_beat: valid=%b idx=%0d, required 1 1", out_valid, out_idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b, required 0", out_valid);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== pat(0)) begin
            errors++;
            $display("FAIL post_reset_beat: valid=%b idx=%0d data=%h, required 1 0 %h", out_valid, out_idx, out_data, pat(0));
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        int exp_idx [6] = '{0, 1, 1, 1, 1, 2};
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        lock      = '0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lock = (k >= 1 && k <= 3) ? 4'b0010 : 4'b0000;
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_idx[k])) begin
                errors++;
                $display("FAIL lock_ready[%0d]: got %b, required one-hot %0d", k, req_ready, exp_idx[k]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx[k]) || out_data !== pat(exp_idx[k])) begin
                errors++;
                $display("FAIL lock_beat[%0d]: valid=%b idx=%0d, required 1 %0d", k, out_valid, out_idx, exp_idx[k]);
            end
        end
        lock = '0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < int'(REQ_NUM); i++) begin
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = pat(i);
        end
`ifdef RR_ARB_LOCK_EN
        lock = '0;
`endif
        #1;
        test_reset();
        test_all_req();
        test_sparse_wrap();
        test_stall();
        test_mid_reset();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
